// File: rtl/isp8_flags_wb_if.sv
// Execute-side bus between the ISP8 sequencer/ALU and the flag/write-back stage.
// The master drives the execute-cycle controls; the slave returns flags,
// the branch predicate and the register-file write port.
interface isp8_flags_wb_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      exe_valid;
  logic [7:0]                dout_alu;
  logic                      cout_alu;
  logic                      flag_upd;
  logic                      set_c;
  logic                      clr_c;
  logic                      set_z;
  logic                      clr_z;
  logic                      wr_rd;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic                      int_push;
  logic                      reti;
  logic [1:0]                cond;

  logic                      carry_flag;
  logic                      zero_flag;
  logic                      cond_true;
  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [7:0]                rf_wdata;
  logic                      stk_err;

  modport master (
    output exe_valid, dout_alu, cout_alu, flag_upd, set_c, clr_c, set_z, clr_z,
           wr_rd, rd_addr, int_push, reti, cond,
    input  carry_flag, zero_flag, cond_true, rf_we, rf_waddr, rf_wdata, stk_err
  );

  modport slave (
    input  exe_valid, dout_alu, cout_alu, flag_upd, set_c, clr_c, set_z, clr_z,
           wr_rd, rd_addr, int_push, reti, cond,
    output carry_flag, zero_flag, cond_true, rf_we, rf_waddr, rf_wdata, stk_err
  );
endinterface

// File: rtl/isp8_flags_wb.sv
// ISP8 execute-result consumer: C/Z flag register, one-cycle register-file
// write-back, interrupt flag shadow stack and branch predicate.
module isp8_flags_wb #(
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned FLAG_STACK_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  isp8_flags_wb_if.slave  bus
);

  localparam int unsigned    SpW    = $clog2(FLAG_STACK_DEPTH + 1);
  localparam logic [SpW-1:0] SpFull = SpW'(FLAG_STACK_DEPTH);

  logic                      c_q, c_d, z_q, z_d;
  logic                      c_exe, z_exe;
  logic [SpW-1:0]            sp_q, sp_d;
  logic                      err_q, err_d;
  logic [1:0]                stk_q [FLAG_STACK_DEPTH];
  logic [1:0]                stk_d [FLAG_STACK_DEPTH];
  logic [1:0]                pop_val;
  logic                      we_q;
  logic [REG_ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]                wdata_q;

  // Flag next-state from the execute cycle alone; explicit set/clr beat the ALU, clr beats set.
  always_comb begin
    c_exe = c_q;
    z_exe = z_q;
    if (bus.exe_valid) begin
      if (bus.flag_upd) begin
        c_exe = bus.cout_alu;
        z_exe = (bus.dout_alu == 8'h00);
      end
      if (bus.set_c) c_exe = 1'b1;
      if (bus.clr_c) c_exe = 1'b0;
      if (bus.set_z) z_exe = 1'b1;
      if (bus.clr_z) z_exe = 1'b0;
    end
  end

  // Shadow stack control; reti has priority over push and over the execute flag update.
  always_comb begin
    c_d     = c_exe;
    z_d     = z_exe;
    sp_d    = sp_q;
    err_d   = err_q;
    stk_d   = stk_q;
    pop_val = 2'b00;
    for (int i = 0; i < int'(FLAG_STACK_DEPTH); i++) begin
      if (sp_q == SpW'(i + 1)) pop_val = stk_q[i];
    end
    if (bus.reti) begin
      if (bus.int_push) err_d = 1'b1;
      if (sp_q != '0) begin
        sp_d       = sp_q - SpW'(1);
        {c_d, z_d} = pop_val;
      end else begin
        c_d   = c_q;
        z_d   = z_q;
        err_d = 1'b1;
      end
    end else if (bus.int_push) begin
      if (sp_q != SpFull) begin
        for (int i = 0; i < int'(FLAG_STACK_DEPTH); i++) begin
          if (sp_q == SpW'(i)) stk_d[i] = {c_exe, z_exe};
        end
        sp_d = sp_q + SpW'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Flag, stack and error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < int'(FLAG_STACK_DEPTH); i++) stk_q[i] <= 2'b00;
    end else begin
      c_q   <= c_d;
      z_q   <= z_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      stk_q <= stk_d;
    end
  end

  // Write-back register; address/data only load on an actual write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 8'h00;
    end else begin
      we_q <= bus.exe_valid & bus.wr_rd;
      if (bus.exe_valid & bus.wr_rd) begin
        waddr_q <= bus.rd_addr;
        wdata_q <= bus.dout_alu;
      end
    end
  end

  // Branch predicate from the registered flags.
  always_comb begin
    case (bus.cond)
      2'b00:   bus.cond_true = z_q;
      2'b01:   bus.cond_true = ~z_q;
      2'b10:   bus.cond_true = c_q;
      default: bus.cond_true = ~c_q;
    endcase
  end

  assign bus.carry_flag = c_q;
  assign bus.zero_flag  = z_q;
  assign bus.rf_we      = we_q;
  assign bus.rf_waddr   = waddr_q;
  assign bus.rf_wdata   = wdata_q;
  assign bus.stk_err    = err_q;

endmodule

// File: tb/tb_isp8_flags_wb.sv
// Self-checking bench for isp8_flags_wb: vector table plus stack/reset sequences.
module tb_isp8_flags_wb;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  isp8_flags_wb_if #(.REG_ADDR_WIDTH(5)) bus ();

  isp8_flags_wb #(
    .REG_ADDR_WIDTH  (5),
    .FLAG_STACK_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ev, upd, sc, cc, sz, cz, wr;
    logic [4:0] rd;
    logic [7:0] dout;
    logic       cout, push, reti;
    logic [1:0] cond;
    logic       e_c, e_z, e_ct, e_we;
    logic [4:0] e_wa;
    logic [7:0] e_wd;
    logic       e_err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.exe_valid = 1'b0; bus.dout_alu = 8'h00; bus.cout_alu = 1'b0;
    bus.flag_upd = 1'b0; bus.set_c = 1'b0; bus.clr_c = 1'b0;
    bus.set_z = 1'b0; bus.clr_z = 1'b0; bus.wr_rd = 1'b0; bus.rd_addr = 5'd0;
    bus.int_push = 1'b0; bus.reti = 1'b0; bus.cond = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_f(input string nm, input logic c, input logic z, input logic err);
    check({nm, "_c"}, 32'(bus.carry_flag), 32'(c));
    check({nm, "_z"}, 32'(bus.zero_flag), 32'(z));
    check({nm, "_err"}, 32'(bus.stk_err), 32'(err));
  endtask

  // One execute cycle with explicit flag controls, optionally pushing.
  task automatic exe_flags(input logic sc, input logic cc, input logic sz, input logic cz,
                           input logic push);
    idle();
    bus.exe_valid = 1'b1; bus.set_c = sc; bus.clr_c = cc; bus.set_z = sz; bus.clr_z = cz;
    bus.int_push = push;
    step();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00,
                1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00,
                1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h7F, 1'b0, 1'b0, 1'b0, 2'b01,
                1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11,
                1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b10,
                1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 8'hA5, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01,
                1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 8'hA5, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10,
                1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 8'hA5, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00,
                1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 8'hA5, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b10,
                1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 8'hA5, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd31, 8'h55, 1'b0, 1'b0, 1'b0, 2'b11,
                1'b0, 1'b1, 1'b1, 1'b1, 5'd31, 8'h55, 1'b0};

    rst_n = 1'b0;
    idle();
    #12;
    chk_f("rst", 1'b0, 1'b0, 1'b0);
    check("rst_we", 32'(bus.rf_we), 32'd0);
    check("rst_wa", 32'(bus.rf_waddr), 32'd0);
    check("rst_wd", 32'(bus.rf_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      bus.exe_valid = vecs[i].ev;   bus.flag_upd = vecs[i].upd;
      bus.set_c = vecs[i].sc;       bus.clr_c = vecs[i].cc;
      bus.set_z = vecs[i].sz;       bus.clr_z = vecs[i].cz;
      bus.wr_rd = vecs[i].wr;       bus.rd_addr = vecs[i].rd;
      bus.dout_alu = vecs[i].dout;  bus.cout_alu = vecs[i].cout;
      bus.int_push = vecs[i].push;  bus.reti = vecs[i].reti;
      bus.cond = vecs[i].cond;
      step();
      chk_f($sformatf("v%0d", i), vecs[i].e_c, vecs[i].e_z, vecs[i].e_err);
      check($sformatf("v%0d_ct", i), 32'(bus.cond_true), 32'(vecs[i].e_ct));
      check($sformatf("v%0d_we", i), 32'(bus.rf_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d_wa", i), 32'(bus.rf_waddr), 32'(vecs[i].e_wa));
      check($sformatf("v%0d_wd", i), 32'(bus.rf_wdata), 32'(vecs[i].e_wd));
    end

    // Fill the stack with pushes carrying the same-cycle flag result.
    exe_flags(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); chk_f("push1", 1'b1, 1'b0, 1'b0);
    exe_flags(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); chk_f("push2", 1'b0, 1'b1, 1'b0);
    exe_flags(1'b1, 1'b0, 1'b1, 1'b0, 1'b1); chk_f("push3", 1'b1, 1'b1, 1'b0);
    exe_flags(1'b0, 1'b1, 1'b0, 1'b1, 1'b1); chk_f("push4", 1'b0, 1'b0, 1'b0);
    idle(); bus.int_push = 1'b1; step();     chk_f("push5", 1'b0, 1'b0, 1'b1);
    // Make the live flags differ from the top entry before popping.
    exe_flags(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); chk_f("pre_pop", 1'b1, 1'b1, 1'b1);
    idle(); bus.reti = 1'b1; step(); chk_f("pop1", 1'b0, 1'b0, 1'b1);
    step();                          chk_f("pop2", 1'b1, 1'b1, 1'b1);
    step();                          chk_f("pop3", 1'b0, 1'b1, 1'b1);
    step();                          chk_f("pop4", 1'b1, 1'b0, 1'b1);
    step();                          chk_f("pop5", 1'b1, 1'b0, 1'b1);

    do_reset();
    chk_f("rst2", 1'b0, 1'b0, 1'b0);
    // Push alongside an ALU update giving C=1 Z=0.
    idle(); bus.exe_valid = 1'b1; bus.flag_upd = 1'b1; bus.dout_alu = 8'h12;
    bus.cout_alu = 1'b1; bus.int_push = 1'b1; step();
    chk_f("push_upd", 1'b1, 1'b0, 1'b0);
    exe_flags(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); chk_f("mod", 1'b0, 1'b1, 1'b0);
    // reti with an ALU update and write-back: popped flags win, write still happens.
    idle(); bus.exe_valid = 1'b1; bus.flag_upd = 1'b1; bus.dout_alu = 8'h00;
    bus.cout_alu = 1'b1; bus.wr_rd = 1'b1; bus.rd_addr = 5'd4; bus.reti = 1'b1; step();
    chk_f("reti_upd", 1'b1, 1'b0, 1'b0);
    check("reti_we", 32'(bus.rf_we), 32'd1);
    check("reti_wa", 32'(bus.rf_waddr), 32'd4);
    check("reti_wd", 32'(bus.rf_wdata), 32'd0);
    idle(); bus.reti = 1'b1; step();
    chk_f("reti_empty", 1'b1, 1'b0, 1'b1);

    // Push and reti together: the pop happens, the push is dropped, error flagged.
    do_reset();
    exe_flags(1'b1, 1'b0, 1'b1, 1'b0, 1'b1); chk_f("pr_push", 1'b1, 1'b1, 1'b0);
    exe_flags(1'b0, 1'b1, 1'b0, 1'b1, 1'b0); chk_f("pr_mod", 1'b0, 1'b0, 1'b0);
    idle(); bus.int_push = 1'b1; bus.reti = 1'b1; step();
    chk_f("pr_both", 1'b1, 1'b1, 1'b1);
    idle(); bus.reti = 1'b1; step();
    chk_f("pr_empty", 1'b1, 1'b1, 1'b1);

    // Asynchronous reset with a pending write-back and a non-empty stack.
    do_reset();
    exe_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); chk_f("ar_push", 1'b1, 1'b0, 1'b0);
    idle(); bus.exe_valid = 1'b1; bus.wr_rd = 1'b1; bus.rd_addr = 5'd6;
    bus.dout_alu = 8'h3C; step();
    check("ar_we1", 32'(bus.rf_we), 32'd1);
    check("ar_wd1", 32'(bus.rf_wdata), 32'h3C);
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("ar_we0", 32'(bus.rf_we), 32'd0);
    check("ar_wa0", 32'(bus.rf_waddr), 32'd0);
    chk_f("ar_flags", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_f("ar_rel", 1'b0, 1'b0, 1'b0);
    idle(); bus.reti = 1'b1; step();
    chk_f("ar_empty", 1'b0, 1'b0, 1'b1);

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
